// File: rtl/obi_instr_pkg.sv
// Shared types and constants for the instruction-side OBI responder.
package obi_instr_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_LSB = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [0:0] gnt_state_e;
  localparam gnt_state_e IDLE = 1'b0;
  localparam gnt_state_e WAIT = 1'b1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/obi_rsp_pipe.sv
// Fixed-latency response pipe: an entry pushed in cycle N appears on the output in cycle N+LAT.
module obi_rsp_pipe
  import obi_instr_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic            rvalid_o,
  output logic [XLEN-1:0] rdata_o
);

  rsp_entry_t stage_q [LAT];
  rsp_entry_t head;

  // Empty slots carry zero data so the output needs no extra gating.
  always_comb begin
    head.valid = push_i;
    head.data  = push_i ? push_data_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= head;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign rvalid_o = stage_q[LAT-1].valid;
  assign rdata_o  = stage_q[LAT-1].data;

endmodule

// File: rtl/obi_instr_mem_responder.sv
// Behavioural OBI instruction-fetch slave: preloadable memory, grant stalls, fixed-latency
// in-order responses, outstanding limiting and sticky protocol/alignment error flags.
module obi_instr_mem_responder
  import obi_instr_pkg::*;
#(
  parameter int unsigned     ADDR_W          = 32,
  parameter int unsigned     DATA_W          = XLEN,
  parameter int unsigned     MEM_WORDS       = 1024,
  parameter int unsigned     RVALID_LAT      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [DATA_W-1:0] FILL_DATA     = NOP_INSTR,
  parameter int unsigned     IDX_W           = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  input  logic [3:0]        stall_cycles_i,
  input  logic              load_we_i,
  input  logic [IDX_W-1:0]  load_idx_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [3:0]        outstanding_o,
  output logic [31:0]       txn_count_o,
  output logic              misalign_err_o,
  output logic              proto_err_o
);

  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(MEM_WORDS) << ADDR_LSB;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  gnt_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [3:0]        outstanding_q, outstanding_d;
  logic [31:0]       txn_q;
  logic              misalign_q, proto_q;

  logic              gnt, hs, full, violation, in_range;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_data;

  // Preload port only; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_idx_i] <= load_data_i;
  end

  assign full      = (outstanding_q == 4'(MAX_OUTSTANDING)) && !instr_rvalid_o;
  assign violation = pend_q && (!instr_req_i || (instr_addr_i != pend_addr_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (violation) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (instr_req_i) begin
            if (stall_cycles_i == 4'd0) begin
              gnt = !full;
            end else begin
              state_d = WAIT;
              cnt_d   = stall_cycles_i;
            end
          end
        end
        WAIT: begin
          // Last wait cycle is cnt_q == 1 so the grant lands N cycles after the request.
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else if (!full) begin
            gnt     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign instr_gnt_o = gnt && rst_n;
  assign hs          = instr_req_i && instr_gnt_o;

  assign word_idx = instr_addr_i[ADDR_LSB +: IDX_W];
  assign in_range = {1'b0, instr_addr_i} < MEM_BYTES;
  assign rd_data  = in_range ? mem[word_idx] : FILL_DATA;

  always_comb begin
    outstanding_d = outstanding_q;
    if (hs && !instr_rvalid_o)      outstanding_d = outstanding_q + 4'd1;
    else if (!hs && instr_rvalid_o) outstanding_d = outstanding_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
      outstanding_q <= '0;
      txn_q         <= '0;
      misalign_q    <= 1'b0;
      proto_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= instr_req_i && !instr_gnt_o;
      pend_addr_q   <= instr_addr_i;
      outstanding_q <= outstanding_d;
      txn_q         <= txn_q + 32'(hs);
      misalign_q    <= misalign_q | (hs && (instr_addr_i[1:0] != 2'b00));
      proto_q       <= proto_q | violation;
    end
  end

  obi_rsp_pipe #(
    .LAT(RVALID_LAT)
  ) u_rsp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (hs),
    .push_data_i(rd_data),
    .rvalid_o   (instr_rvalid_o),
    .rdata_o    (instr_rdata_o)
  );

  assign outstanding_o  = outstanding_q;
  assign txn_count_o    = txn_q;
  assign misalign_err_o = misalign_q;
  assign proto_err_o    = proto_q;

endmodule
